// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the block-RAM port arbiter.
package bram_arb_pkg;

    localparam int unsigned BRAM_AW   = 15;
    localparam int unsigned BRAM_DW   = 32;

    localparam int unsigned REQ_FETCH = 0;
    localparam int unsigned REQ_DATA  = 1;
    localparam int unsigned REQ_DMA   = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } arb_state_e;

    // Width of a requester index; at least one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import bram_arb_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            valid,
    output logic [PW-1:0]   idx
);

    logic [PW-1:0] slot;

    // Scan from the far end so the slot closest to ptr is written last and wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        slot  = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            slot = PW'((32'(ptr) + 32'(k)) % NREQ);
            if (req[slot]) begin
                valid = 1'b1;
                idx   = slot;
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin multi-master controller for a single-port block RAM with
// one-cycle registered read latency; one access every four cycles.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = BRAM_AW,
    parameter int unsigned DW   = BRAM_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    rdy,
    output logic [DW-1:0]      rdata,
    output logic               busy,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_din,
    output logic               ram_we,
    input  logic [DW-1:0]      ram_dout
);

    localparam int unsigned PW = ptr_width(NREQ);

    arb_state_e      state, state_nxt;
    logic [PW-1:0]   gnt, gnt_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic            wr, wr_nxt;
    logic [NREQ-1:0] rdy_nxt;
    logic [DW-1:0]   rdata_nxt;
    logic [AW-1:0]   addr_nxt;
    logic [DW-1:0]   din_nxt;
    logic            we_nxt;
    logic            busy_nxt;

    logic            pick_valid;
    logic [PW-1:0]   pick_idx;

    logic [AW-1:0]   slot_addr  [NREQ];
    logic [DW-1:0]   slot_wdata [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        assign slot_addr[i]  = req_addr[i*AW +: AW];
        assign slot_wdata[i] = req_wdata[i*DW +: DW];
    end

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state and registered-output logic; ram_addr/ram_din hold between accesses.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        wr_nxt    = wr;
        rdy_nxt   = '0;
        rdata_nxt = rdata;
        addr_nxt  = ram_addr;
        din_nxt   = ram_din;
        we_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    gnt_nxt   = pick_idx;
                    addr_nxt  = slot_addr[pick_idx];
                    din_nxt   = slot_wdata[pick_idx];
                    we_nxt    = req_we[pick_idx];
                    wr_nxt    = req_we[pick_idx];
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (!wr) begin
                    rdata_nxt = ram_dout;
                end
                rdy_nxt[gnt] = 1'b1;
                state_nxt    = DONE;
            end
            DONE: begin
                ptr_nxt   = (gnt == PW'(NREQ - 1)) ? '0 : gnt + PW'(1);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            ptr      <= '0;
            wr       <= 1'b0;
            rdy      <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            ptr      <= ptr_nxt;
            wr       <= wr_nxt;
            rdy      <= rdy_nxt;
            rdata    <= rdata_nxt;
            busy     <= busy_nxt;
            ram_addr <= addr_nxt;
            ram_din  <= din_nxt;
            ram_we   <= we_nxt;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: per-requester drivers, a RAM model,
// and a monitor that checks grant order, data and RAM-port behaviour.
module tb_bram_port_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned AW   = 15;
    localparam int unsigned DW   = 32;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            raise;
    } acc_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    rdy;
    logic [DW-1:0]      rdata;
    logic               busy;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_din;
    logic               ram_we;
    logic [DW-1:0]      ram_dout;

    bram_port_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rdy       (rdy),
        .rdata     (rdata),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    acc_t stim_q [NREQ][$];
    acc_t exp_q  [NREQ][$];
    logic [NREQ-1:0] active = '0;

    logic [DW-1:0]      shadow [logic [AW-1:0]];
    logic [AW+DW-1:0]   we_log [$];
    logic [DW-1:0]      model_rdata = '0;
    int                 last   = NREQ - 1;
    int                 c_prev = 0;
    int                 we_pulses   = 0;
    int                 writes_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {a[7:0], 9'h0, a} ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [DW-1:0] exp_mem(input logic [AW-1:0] a);
        return shadow.exists(a) ? shadow[a] : init_val(a);
    endfunction

    function automatic acc_t mk(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        acc_t a;
        a.we = we; a.addr = addr; a.data = data; a.raise = 0;
        return a;
    endfunction

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NREQ; i++) n += stim_q[i].size() + exp_q[i].size();
        return n;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Single-port RAM, one-cycle registered read.
    initial begin
        logic [DW-1:0] mem [2**AW];
        logic [DW-1:0] rd;
        for (int a = 0; a < 2**AW; a++) mem[a] = init_val(AW'(a));
        mem[16] = 32'hDEADBEEF;
        ram_dout <= '0;
        forever begin
            @(posedge clk);
            rd = mem[ram_addr];
            if (ram_we) mem[ram_addr] = ram_din;
            ram_dout <= rd;
        end
    end

    // Requesters: raise a pending access, hold it until its rdy, then drop or reissue.
    initial begin
        acc_t a;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (active[i] && rdy[i]) active[i] = 1'b0;
                if (!active[i]) begin
                    if (!rst && stim_q[i].size() > 0) begin
                        a = stim_q[i].pop_front();
                        a.raise = cyc;
                        exp_q[i].push_back(a);
                        req[i]    = 1'b1;
                        req_we[i] = a.we;
                        req_addr[i*AW +: AW]  = a.addr;
                        req_wdata[i*DW +: DW] = a.data;
                        active[i] = 1'b1;
                    end else begin
                        req[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: a request counts as pending at a grant edge if raised before it;
    // the winner is the first pending one after the last served requester.
    initial begin
        acc_t a;
        logic [AW+DW-1:0] e;
        logic prev_we;
        int w, j, minr;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_we = 1'b0;
            end else begin
                if (ram_we) begin
                    check("we_single_cycle", 64'(prev_we), 0);
                    we_log.push_back({ram_addr, ram_din});
                    we_pulses++;
                end
                prev_we = ram_we;
                if (rdy != '0) begin
                    w = -1;
                    for (int k = 1; k <= NREQ; k++) begin
                        j = (last + k) % int'(NREQ);
                        if (w < 0 && exp_q[j].size() > 0 && exp_q[j][0].raise <= cyc - 3) w = j;
                    end
                    if (w < 0) begin
                        check("rdy_unexpected", 64'(rdy), 0);
                    end else begin
                        a = exp_q[w].pop_front();
                        check("rdy_winner", 64'(rdy), 64'(1) << w);
                        check("rdy_spacing", 64'(cyc - c_prev >= 4), 1);
                        if (cyc >= c_prev + 5) begin
                            minr = a.raise;
                            for (int k = 0; k < NREQ; k++)
                                if (exp_q[k].size() > 0 && exp_q[k][0].raise < minr) minr = exp_q[k][0].raise;
                            check("no_stall", 64'(minr > cyc - 4), 1);
                        end
                        if (a.we) begin
                            writes_done++;
                            shadow[a.addr] = a.data;
                            check("rdata_hold_on_write", 64'(rdata), 64'(model_rdata));
                            check("we_seen", 64'(we_log.size()), 1);
                            if (we_log.size() > 0) begin
                                e = we_log.pop_front();
                                check("we_addr", 64'(e[AW+DW-1:DW]), 64'(a.addr));
                                check("we_din", 64'(e[DW-1:0]), 64'(a.data));
                            end
                        end else begin
                            check("no_we_on_read", 64'(we_log.size()), 0);
                            model_rdata = exp_mem(a.addr);
                            check("rdata", 64'(rdata), 64'(model_rdata));
                        end
                        last   = w;
                        c_prev = cyc;
                    end
                end
            end
        end
    end

    // After reset release: ptr back to 0, held requests count as raised now.
    task automatic model_reset();
        acc_t a;
        last = NREQ - 1;
        c_prev = cyc - 1;
        model_rdata = '0;
        we_log.delete();
        for (int i = 0; i < NREQ; i++) begin
            if (exp_q[i].size() > 0) begin
                a = exp_q[i].pop_front();
                a.raise = cyc;
                exp_q[i].push_front(a);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rdy", 64'(rdy), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_ram_we", 64'(ram_we), 0);
        check("rst_ram_addr", 64'(ram_addr), 0);
        check("rst_ram_din", 64'(ram_din), 0);
        check("rst_rdata", 64'(rdata), 0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (pending() > 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_all_served", 64'(pending()), 0);
    endtask

    task automatic wait_busy();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 20);
        check("wait_busy", 64'(busy), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        acc_t a;
        int n;
        shadow[15'h010] = 32'hDEADBEEF;
        do_reset();

        // Single read after reset.
        stim_q[1].push_back(mk(1'b0, 15'h010, '0));
        drain(100);
        @(posedge clk); #1;
        check("busy_after_read", 64'(busy), 0);
        check("no_we_single_read", 64'(we_pulses), 0);

        // Write then read back the same address.
        stim_q[0].push_back(mk(1'b1, 15'h7FF, 32'h12345678));
        drain(100);
        check("we_pulses_one_write", 64'(we_pulses), 1);
        stim_q[1].push_back(mk(1'b0, 15'h7FF, '0));
        drain(100);

        // All three requesters held from reset.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NREQ; i++)
                stim_q[i].push_back(mk(1'b0, AW'(i * 4 + k), '0));
        do_reset();
        drain(200);

        // Move ptr to 2, then contend 0 and 1 with 2 arriving mid-access.
        stim_q[1].push_back(mk(1'b0, 15'h020, '0));
        drain(100);
        @(posedge clk); #1;
        stim_q[0].push_back(mk(1'b0, 15'h021, '0));
        stim_q[1].push_back(mk(1'b0, 15'h022, '0));
        wait_busy();
        stim_q[2].push_back(mk(1'b0, 15'h023, '0));
        drain(200);

        // Request fields changed after the grant must not reach the RAM.
        @(posedge clk); #1;
        stim_q[0].push_back(mk(1'b1, 15'h123, 32'hA5A5_0F0F));
        wait_busy();
        req_addr[0 +: AW]  = 15'h456;
        req_wdata[0 +: DW] = 32'h0BAD_F00D;
        req_we[0]          = 1'b0;
        drain(100);
        stim_q[2].push_back(mk(1'b0, 15'h123, '0));
        stim_q[1].push_back(mk(1'b0, 15'h456, '0));
        drain(100);

        // Reset during CAPTURE of a read; held requests restart afterwards.
        @(posedge clk); #1;
        stim_q[0].push_back(mk(1'b0, 15'h7FF, '0));
        stim_q[2].push_back(mk(1'b0, 15'h010, '0));
        wait_busy();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 0);
        check("abort_ram_we", 64'(ram_we), 0);
        check("abort_rdy", 64'(rdy), 0);
        @(negedge clk);
        check("abort_rdy_hold", 64'(rdy), 0);
        check("abort_rdata", 64'(rdata), 0);
        rst = 1'b0;
        model_reset();
        drain(100);

        // Randomized contention over a small address window.
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                n = int'($urandom_range(0, 4));
                for (int k = 0; k < n; k++) begin
                    a = mk(1'($urandom_range(0, 1)), 15'h0200 | AW'($urandom_range(0, 15)), $urandom);
                    stim_q[i].push_back(a);
                end
            end
            repeat ($urandom_range(0, 25)) @(negedge clk);
        end
        drain(2000);

        check("we_pulses_total", 64'(we_pulses), 64'(writes_done));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
